// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEF   = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: icache request/response, hazard/EX/decode controls and
// the fetch-decode latch outputs. master = fetch stage, slave = surroundings.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t f_instr;
  word_t f_pc4;
  logic  f_valid;

  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, f_instr, f_pc4, f_valid
  );

  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  iREN, iaddr, f_instr, f_pc4, f_valid
  );

endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, requests words from the icache, buffers one word
// across a decode stall, applies EX redirects and stops for good on HALT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_INIT   = PC_INIT_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_pc_q, pend_pc_d;
  logic         buf_valid_q, buf_valid_d;
  word_t        buf_instr_q, buf_instr_d;
  word_t        buf_pc4_q, buf_pc4_d;

  word_t pc_plus4;
  logic  src_valid;
  word_t src_instr;
  word_t src_pc4;

  assign pc_plus4 = pc_q + 32'd4;

  // State, PC and hold-buffer registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      pend_pc_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  // Next-state: redirect > halt > buffer drain > advance on hit
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    unique case (state_q)
      FETCH: begin
        if (bus.redirect && !bus.ihit) begin
          // keep iaddr stable for the outstanding miss; retarget once it lands
          pend_pc_d   = bus.redirect_pc;
          buf_valid_d = 1'b0;
          state_d     = SQUASH;
        end else if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          buf_valid_d = 1'b0;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (buf_valid_q && !bus.stall) begin
          buf_valid_d = 1'b0;
        end else if (!buf_valid_q && bus.ihit) begin
          pc_d = pc_plus4;
          if (bus.stall) begin
            buf_instr_d = bus.iload;
            buf_pc4_d   = pc_plus4;
            buf_valid_d = 1'b1;
          end
        end
      end
      SQUASH: begin
        // youngest redirect wins, including one arriving with the stale word
        if (bus.redirect) pend_pc_d = bus.redirect_pc;
        if (bus.ihit) begin
          pc_d    = bus.redirect ? bus.redirect_pc : pend_pc_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Icache request and fetch-decode latch outputs
  always_comb begin
    bus.iREN  = (state_q != HALTED) && !buf_valid_q;
    bus.iaddr = pc_q;
    src_valid = 1'b0;
    src_instr = NOP_INSTR;
    src_pc4   = '0;
    if (buf_valid_q) begin
      src_valid = 1'b1;
      src_instr = buf_instr_q;
      src_pc4   = buf_pc4_q;
    end else if (state_q == FETCH && bus.ihit) begin
      src_valid = 1'b1;
      src_instr = bus.iload;
      src_pc4   = pc_plus4;
    end
    bus.f_valid = src_valid && !bus.redirect && (state_q != HALTED);
    bus.f_instr = bus.f_valid ? src_instr : NOP_INSTR;
    bus.f_pc4   = bus.f_valid ? src_pc4 : '0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// transaction-level model (PC, pending target, queue of held words).
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [97:0] obs;
  logic [97:0] exp_v;
  assign obs = {bus.iREN, bus.iaddr, bus.f_valid, bus.f_instr, bus.f_pc4};

  // reference model state
  word_t       m_pc, m_pend;
  bit          m_halted, m_squash;
  logic [63:0] m_hold[$];

  // apply one cycle of inputs mid-period; outputs settle 1ns later
  task automatic drive(input logic r, input logic h, input word_t ld, input logic st,
                       input logic rd, input word_t rpc, input logic hl);
    @(negedge CLK);
    RST = r; bus.ihit = h; bus.iload = ld; bus.stall = st;
    bus.redirect = rd; bus.redirect_pc = rpc; bus.halt = hl;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL reset_out got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_seq_fetch();
    drive(0, 1, 32'h11, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b1, 32'h11, 32'h4};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL seq_w0 got=%h exp=%h", obs, exp_v); end
    drive(0, 1, 32'h22, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h4, 1'b1, 32'h22, 32'h8};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL seq_w1 got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_stall_buffer();
    drive(0, 1, 32'h33, 1, 0, 0, 0);
    exp_v = {1'b1, 32'h8, 1'b1, 32'h33, 32'hC};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL stall_capture got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 32'hDEAD, 1, 0, 0, 0);
    exp_v = {1'b0, 32'hC, 1'b1, 32'h33, 32'hC};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL stall_hold got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 32'hDEAD, 0, 0, 0, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL stall_drain got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'hC, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL stall_resume got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_miss_redirect();
    drive(0, 1, 32'h44, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h100, 0);
    exp_v = {1'b1, 32'h10, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL miss_redir got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL squash_wait got=%h exp=%h", obs, exp_v); end
    drive(0, 1, 32'h55, 0, 0, 0, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL squash_drop got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h100, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL squash_target got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_hit_redirect();
    drive(0, 1, 32'h66, 0, 1, 32'h40, 0);
    exp_v = {1'b1, 32'h100, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL hit_redir got=%h exp=%h", obs, exp_v); end
    drive(0, 1, 32'h67, 0, 1, 32'h40, 1);
    exp_v = {1'b1, 32'h40, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL redir_halt got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL redir_over_halt got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_halt();
    drive(0, 1, 0, 0, 1, 32'h18, 0);
    drive(0, 1, 32'h77, 0, 0, 0, 1);
    exp_v = {1'b1, 32'h18, 1'b1, 32'h77, 32'h1C};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL halt_cycle got=%h exp=%h", obs, exp_v); end
    exp_v = {1'b0, 32'h18, 1'b0, NOP, 32'h0};
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL halted got=%h exp=%h", obs, exp_v); end
    drive(0, 1, 32'h78, 0, 1, 32'h300, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL halted_redir got=%h exp=%h", obs, exp_v); end
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL halted_frozen got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL halt_reset got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_in_squash();
    drive(0, 0, 0, 0, 1, 32'h200, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL sq_rst_pre got=%h exp=%h", obs, exp_v); end
    drive(0, 1, 32'h88, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b1, 32'h88, 32'h4};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL sq_rst_fetch got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h4, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL sq_rst_next got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0);
    drive(0, 1, 32'h99, 0, 0, 0, 0);
    exp_v = {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h99, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_pc4 got=%h exp=%h", obs, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_v = {1'b1, 32'h0, 1'b0, NOP, 32'h0};
    n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_addr got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_random();
    logic  r, h, st, rd, hl, e_ren, e_val;
    word_t ld, rpc, e_ins, e_pc4;
    int    halt_cnt;
    drive(1, 0, 0, 0, 0, 0, 0);
    m_pc = 32'h0; m_pend = 32'h0; m_halted = 0; m_squash = 0; m_hold.delete();
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      e_ren = !m_halted && (m_hold.size() == 0);
      r   = ($urandom_range(0, 99) == 0) || (halt_cnt > 6);
      h   = e_ren && ($urandom_range(0, 2) != 0);
      ld  = $urandom;
      st  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      hl  = ($urandom_range(0, 39) == 0);
      drive(r, h, ld, st, rd, rpc, hl);
      // expected outputs from the model
      e_val = 0; e_ins = NOP; e_pc4 = 32'h0;
      if (!m_halted && !rd) begin
        if (m_hold.size() != 0) begin
          e_val = 1; e_ins = m_hold[0][63:32]; e_pc4 = m_hold[0][31:0];
        end else if (!m_squash && h) begin
          e_val = 1; e_ins = ld; e_pc4 = m_pc + 32'd4;
        end
      end
      exp_v = {e_ren, m_pc, e_val, e_ins, e_pc4};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rand_cycle%0d got=%h exp=%h", i, obs, exp_v);
      end
      // advance the model by one clock
      if (r) begin
        m_pc = 32'h0; m_halted = 0; m_squash = 0; m_hold.delete(); halt_cnt = 0;
      end else if (m_halted) begin
        halt_cnt++;
      end else if (m_squash) begin
        if (rd) m_pend = rpc;
        if (h) begin m_pc = m_pend; m_squash = 0; end
      end else if (rd) begin
        m_hold.delete();
        if (h) m_pc = rpc;
        else begin m_pend = rpc; m_squash = 1; end
      end else if (hl) begin
        m_halted = 1;
      end else if (m_hold.size() != 0) begin
        if (!st) void'(m_hold.pop_front());
      end else if (h) begin
        if (st) m_hold.push_back({ld, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    bus.ihit = 0; bus.iload = 0; bus.stall = 0;
    bus.redirect = 0; bus.redirect_pc = 0; bus.halt = 0;
    test_reset();
    test_seq_fetch();
    test_stall_buffer();
    test_miss_redirect();
    test_hit_redirect();
    test_halt();
    test_reset_in_squash();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
